// File: rtl/square_root_pkg.sv
// Shared types for the sequential square-root unit.
package square_root_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StCalc
  } state_e;

endpackage

// File: rtl/square_root.sv
// Sequential fixed-point square root using the restoring digit-by-digit method.
// Produces one root bit per clock and holds the result until the next completion.
module square_root
  import square_root_pkg::*;
#(
  parameter int unsigned WIDTH  = 48,
  parameter int unsigned F_BITS = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic             busy,
  output logic             valid,
  input  logic [WIDTH-1:0] radicand,
  output logic [WIDTH-1:0] sq_root,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned XW   = WIDTH + F_BITS;
  localparam int unsigned ITER = XW / 2;
  localparam int unsigned AW   = WIDTH + 2;
  localparam int unsigned CW   = $clog2(ITER + 1);

  state_e           state_q, state_d;
  logic [XW-1:0]    x_q, x_d;
  logic [WIDTH-1:0] ac_q, ac_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] root_q, root_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic [AW-1:0]    ac_sh;
  logic [AW-1:0]    trial;
  logic [AW-1:0]    ac_next;
  logic [WIDTH-1:0] q_next;
  logic             take;
  logic             unused_ac_msb;

  // The accumulator stays below 2^(ITER+1), so its two top bits are always zero.
  assign ac_sh   = {ac_q, x_q[XW-1 -: 2]};
  assign trial   = {q_q, 2'b01};
  assign take    = (ac_sh >= trial);
  assign ac_next = take ? (ac_sh - trial) : ac_sh;
  assign q_next  = {q_q[WIDTH-2:0], take};
  assign unused_ac_msb = ^ac_next[AW-1:WIDTH];

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    ac_d    = ac_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    root_d  = root_q;
    rem_d   = rem_q;

    case (state_q)
      StIdle: begin
        if (enable) begin
          x_d     = XW'(radicand) << F_BITS;
          ac_d    = '0;
          q_d     = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StCalc;
        end
      end
      StCalc: begin
        x_d   = x_q << 2;
        ac_d  = ac_next[WIDTH-1:0];
        q_d   = q_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) begin
          root_d  = q_next;
          rem_d   = ac_next[WIDTH-1:0];
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      ac_q    <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      root_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      ac_q    <= ac_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
    end
  end

  assign busy      = busy_q;
  assign valid     = valid_q;
  assign sq_root   = root_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_square_root.sv
// Directed self-checking bench for square_root at default parameters (Q20.28).
module tb_square_root;

  localparam int W = 48;
  localparam int F = 28;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         busy;
  logic         valid;
  logic [W-1:0] radicand;
  logic [W-1:0] sq_root;
  logic [W-1:0] remainder;

  int pass_cnt  = 0;
  int total_cnt = 0;

  square_root #(.WIDTH(W), .F_BITS(F)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .busy      (busy),
    .valid     (valid),
    .radicand  (radicand),
    .sq_root   (sq_root),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  // Reference: binary search for the largest r with r*r <= rad * 2^F.
  function automatic logic [127:0] model_n(input logic [W-1:0] rad);
    logic [127:0] n;
    n = 128'(rad) << F;
    return n;
  endfunction

  function automatic logic [W-1:0] model_root(input logic [W-1:0] rad);
    logic [127:0] n, lo, hi, mid;
    n  = model_n(rad);
    lo = 0;
    hi = 128'd1 << 40;
    while (lo < hi) begin
      mid = (lo + hi + 1) >> 1;
      if (mid * mid <= n) lo = mid;
      else hi = mid - 1;
    end
    return lo[W-1:0];
  endfunction

  function automatic logic [W-1:0] model_rem(input logic [W-1:0] rad);
    logic [127:0] r, d;
    r = 128'(model_root(rad));
    d = model_n(rad) - r * r;
    return d[W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse enable for one edge and wait for valid; lat counts samples from the start edge.
  task automatic run_op(input logic [W-1:0] rad, output int lat, output int busy_cyc);
    enable   = 1'b1;
    radicand = rad;
    tick();
    enable   = 1'b0;
    lat      = 1;
    busy_cyc = 0;
    while (!valid && lat < 100) begin
      if (busy) busy_cyc++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    enable   = 1'b1;
    radicand = 48'hFFFF_FFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++;
      if ({busy, valid, sq_root, remainder} !== '0) begin
        $display("FAIL reset_cyc%0d busy=%b valid=%b root=%h rem=%h, required all zero",
                 i, busy, valid, sq_root, remainder);
      end else pass_cnt++;
    end
    rst    = 1'b0;
    enable = 1'b0;
    tick();
  endtask

  task automatic test_exact();
    int lat, bc;
    run_op(48'd64 << F, lat, bc);
    total_cnt++;
    if (lat !== 39) $display("FAIL exact_latency got %0d required 39", lat);
    else pass_cnt++;
    total_cnt++;
    if (bc !== 38) $display("FAIL exact_busy_cycles got %0d required 38", bc);
    else pass_cnt++;
    total_cnt++;
    if (sq_root !== (48'd8 << F)) $display("FAIL exact_root got %h required %h",
                                           sq_root, 48'd8 << F);
    else pass_cnt++;
    total_cnt++;
    if (remainder !== 48'd0) $display("FAIL exact_rem got %h required 0", remainder);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) tick();
    total_cnt++;
    if (busy !== 1'b0 || valid !== 1'b0 || sq_root !== (48'd8 << F)) begin
      $display("FAIL exact_hold busy=%b valid=%b root=%h required 0 0 %h",
               busy, valid, sq_root, 48'd8 << F);
    end else pass_cnt++;
  endtask

  task automatic test_fraction();
    int lat, bc;
    run_op(48'd1 << (F - 2), lat, bc);  // 0.25
    total_cnt++;
    if (sq_root !== (48'd1 << (F - 1)) || remainder !== 48'd0) begin
      $display("FAIL frac_quarter root=%h rem=%h required %h 0",
               sq_root, remainder, 48'd1 << (F - 1));
    end else pass_cnt++;
  endtask

  task automatic test_zero();
    int lat, bc;
    run_op(48'd0, lat, bc);
    total_cnt++;
    if (valid !== 1'b1 || sq_root !== 48'd0 || remainder !== 48'd0) begin
      $display("FAIL zero valid=%b root=%h rem=%h required 1 0 0", valid, sq_root, remainder);
    end else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] rads [3];
    int           ints [3];
    int           n;
    rads[0] = (48'd1035000 << F) | (48'd9 << (F - 4));
    rads[1] = (48'd2808 << F) | (48'd9 << (F - 4));
    rads[2] = (48'd43528 << F) | (48'd13 << (F - 4));
    ints[0] = 1017;
    ints[1] = 52;
    ints[2] = 208;
    enable   = 1'b1;
    radicand = rads[0];
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!valid && n < 100);
      total_cnt++;
      if (n !== 39) $display("FAIL b2b_spacing%0d got %0d required 39", i, n);
      else pass_cnt++;
      total_cnt++;
      if (sq_root !== model_root(rads[i]) || remainder !== model_rem(rads[i])) begin
        $display("FAIL b2b_result%0d root=%h rem=%h required %h %h", i, sq_root, remainder,
                 model_root(rads[i]), model_rem(rads[i]));
      end else pass_cnt++;
      total_cnt++;
      if (int'(sq_root[W-1:F]) !== ints[i]) begin
        $display("FAIL b2b_int%0d got %0d required %0d", i, sq_root[W-1:F], ints[i]);
      end else pass_cnt++;
      if (i < 2) radicand = rads[i + 1];
      else enable = 1'b0;
    end
    tick();
    tick();
  endtask

  task automatic test_robust();
    logic [W-1:0] a, b;
    int           n;
    bit           seen;
    a = (48'd12345 << F) | 48'h0ABC_DEF;
    b = 48'd7 << F;
    enable   = 1'b1;
    radicand = a;
    tick();
    n = 1;
    for (int i = 0; i < 10; i++) begin
      radicand = b ^ 48'(i);
      enable   = i[0];
      tick();
      n++;
    end
    enable = 1'b0;
    while (!valid && n < 100) begin
      tick();
      n++;
    end
    total_cnt++;
    if (n !== 39 || sq_root !== model_root(a) || remainder !== model_rem(a)) begin
      $display("FAIL robust_ignore lat=%0d root=%h rem=%h required 39 %h %h", n, sq_root,
               remainder, model_root(a), model_rem(a));
    end else pass_cnt++;

    // Abort mid-calculation.
    enable   = 1'b1;
    radicand = b;
    tick();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    total_cnt++;
    if ({busy, valid, sq_root, remainder} !== '0) begin
      $display("FAIL robust_abort busy=%b valid=%b root=%h rem=%h required all zero",
               busy, valid, sq_root, remainder);
    end else pass_cnt++;
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (valid || busy) seen = 1'b1;
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL robust_no_valid got activity=1 required 0");
    else pass_cnt++;

    run_op(b, n, n);
    total_cnt++;
    if (sq_root !== model_root(b) || remainder !== model_rem(b)) begin
      $display("FAIL robust_restart root=%h rem=%h required %h %h", sq_root, remainder,
               model_root(b), model_rem(b));
    end else pass_cnt++;
  endtask

  task automatic test_max();
    int lat, bc;
    logic [W-1:0] m;
    m = '1;
    run_op(m, lat, bc);
    total_cnt++;
    if (sq_root !== model_root(m) || remainder !== model_rem(m)) begin
      $display("FAIL max root=%h rem=%h required %h %h", sq_root, remainder,
               model_root(m), model_rem(m));
    end else pass_cnt++;
  endtask

  initial begin
    rst      = 1'b1;
    enable   = 1'b0;
    radicand = '0;
    test_reset();
    test_exact();
    test_fraction();
    test_zero();
    test_back_to_back();
    test_robust();
    test_max();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
